// File: rtl/fsm_event_decoder_if.sv
// Round-report valid/ready channel from fsm_event_decoder to the monitor/scoreboard.
// The decoder drives through the master modport and the consumer uses the slave modport.
interface fsm_event_decoder_if #(
    parameter int CNT_W = 8
);
    logic             rpt_valid;
    logic             rpt_ready;
    logic [CNT_W-1:0] rpt_len;

    modport master (output rpt_valid, output rpt_len, input rpt_ready);
    modport slave  (input rpt_valid, input rpt_len, output rpt_ready);
endinterface

// File: rtl/fsm_event_decoder.sv
// Rebuilds the idle/runa/runb transmitter state from its one-hot transition pulses,
// flags ordering errors and reports each round's length. Optional macro: FSM_DEC_STRICT_IDLE_EN.
module fsm_event_decoder #(
    parameter int CNT_W   = 8,
    parameter int MAX_LEN = 200
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                c,
    input  logic                d,
    input  logic                e,
    input  logic                h,
    input  logic                err_clr,
    output logic [1:0]          trk_state,
    output logic                err,
    output logic [1:0]          err_code,
    fsm_event_decoder_if.master rpt,
    output logic                rpt_ovf,
    output logic [CNT_W-1:0]    round_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUNA = 2'b01,
        S_RUNB = 2'b10,
        S_ERR  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        E_NONE    = 2'b00,
        E_ILLEGAL = 2'b01,
        E_MULTI   = 2'b10,
        E_TIMEOUT = 2'b11
    } err_code_t;

    localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);

    state_t           state_q, state_nxt;
    err_code_t        code_q, code_nxt;
    logic [CNT_W-1:0] len_q, len_nxt;
    logic [CNT_W-1:0] round_cnt_q;
    logic [CNT_W-1:0] rpt_len_q;
    logic             rpt_valid_q;
    logic             rpt_ovf_q;
    logic             round_done;

    logic [2:0] n_pulse;
    logic       multi;
    logic       no_pulse;
    logic       timeout;

    assign n_pulse  = {2'b00, c} + {2'b00, d} + {2'b00, e} + {2'b00, h};
    assign multi    = (n_pulse > 3'd1);
    assign no_pulse = (n_pulse == 3'd0);
    // >= rather than == so a runb entered exactly at the limit still times out.
    assign timeout  = (len_q >= MAX_LEN_C);

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt  = state_q;
        code_nxt   = code_q;
        len_nxt    = len_q;
        round_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (multi) begin
                    state_nxt = S_ERR;
                    code_nxt  = E_MULTI;
                end else if (d) begin
                    state_nxt = S_RUNA;
                    len_nxt   = CNT_W'(1);
                end else if (e || h) begin
                    state_nxt = S_ERR;
                    code_nxt  = E_ILLEGAL;
`ifdef FSM_DEC_STRICT_IDLE_EN
                end else if (no_pulse) begin
                    state_nxt = S_ERR;
                    code_nxt  = E_ILLEGAL;
`endif
                end
            end
            S_RUNA: begin
                if (multi) begin
                    state_nxt = S_ERR;
                    code_nxt  = E_MULTI;
                end else if (e) begin
                    state_nxt = S_RUNB;
                    len_nxt   = len_q + 1'b1;
                end else if (!no_pulse) begin
                    state_nxt = S_ERR;
                    code_nxt  = E_ILLEGAL;
                end else if (timeout) begin
                    state_nxt = S_ERR;
                    code_nxt  = E_TIMEOUT;
                end else begin
                    len_nxt = len_q + 1'b1;
                end
            end
            S_RUNB: begin
                if (multi) begin
                    state_nxt = S_ERR;
                    code_nxt  = E_MULTI;
                end else if (h) begin
                    state_nxt  = S_IDLE;
                    len_nxt    = '0;
                    round_done = 1'b1;
                end else if (!no_pulse) begin
                    state_nxt = S_ERR;
                    code_nxt  = E_ILLEGAL;
                end else if (timeout) begin
                    state_nxt = S_ERR;
                    code_nxt  = E_TIMEOUT;
                end else begin
                    len_nxt = len_q + 1'b1;
                end
            end
            S_ERR: begin
                if (err_clr) begin
                    state_nxt = S_IDLE;
                    code_nxt  = E_NONE;
                    len_nxt   = '0;
                end
            end
            default: state_nxt = S_ERR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            code_q  <= E_NONE;
            len_q   <= '0;
        end else begin
            state_q <= state_nxt;
            code_q  <= code_nxt;
            len_q   <= len_nxt;
        end
    end

    // A completion arriving while a report is stuck is counted but its report is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            round_cnt_q <= '0;
            rpt_valid_q <= 1'b0;
            rpt_len_q   <= '0;
            rpt_ovf_q   <= 1'b0;
        end else begin
            if (round_done) begin
                round_cnt_q <= round_cnt_q + 1'b1;
            end
            if (round_done && (!rpt_valid_q || rpt.rpt_ready)) begin
                rpt_valid_q <= 1'b1;
                rpt_len_q   <= len_q + 1'b1;
            end else if (round_done) begin
                rpt_ovf_q <= 1'b1;
            end else if (rpt.rpt_ready) begin
                rpt_valid_q <= 1'b0;
            end
        end
    end

    assign trk_state     = state_q;
    assign err           = (state_q == S_ERR);
    assign err_code      = code_q;
    assign rpt.rpt_valid = rpt_valid_q;
    assign rpt.rpt_len   = rpt_len_q;
    assign rpt_ovf       = rpt_ovf_q;
    assign round_cnt     = round_cnt_q;

endmodule

// File: tb/tb_fsm_event_decoder.sv
// Directed bench for fsm_event_decoder: expected report lengths are queued when a round is
// driven and compared when the report is handed over (valid & ready before the edge).
module tb_fsm_event_decoder;

    localparam int CNT_W   = 8;
    localparam int MAX_LEN = 200;

    localparam logic [3:0] P_0 = 4'b0000;
    localparam logic [3:0] P_C = 4'b1000;
    localparam logic [3:0] P_D = 4'b0100;
    localparam logic [3:0] P_E = 4'b0010;
    localparam logic [3:0] P_H = 4'b0001;
`ifdef FSM_DEC_STRICT_IDLE_EN
    localparam logic [3:0] P_I = P_C;
`else
    localparam logic [3:0] P_I = P_0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             c = 1'b0, d = 1'b0, e = 1'b0, h = 1'b0;
    logic             err_clr = 1'b0;
    logic             ready = 1'b0;
    logic [1:0]       trk_state;
    logic             err;
    logic [1:0]       err_code;
    logic             rpt_ovf;
    logic [CNT_W-1:0] round_cnt;

    int total = 0;
    int bad   = 0;
    logic [CNT_W-1:0] exp_q[$];

    fsm_event_decoder_if #(.CNT_W(CNT_W)) rpt_if ();

    fsm_event_decoder #(.CNT_W(CNT_W), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .c         (c),
        .d         (d),
        .e         (e),
        .h         (h),
        .err_clr   (err_clr),
        .trk_state (trk_state),
        .err       (err),
        .err_code  (err_code),
        .rpt       (rpt_if),
        .rpt_ovf   (rpt_ovf),
        .round_cnt (round_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, score any handshake that completes at this edge, sample #1 after.
    task automatic cyc(input logic [3:0] cdeh, input logic clr);
        logic has;
        {c, d, e, h} = cdeh;
        err_clr = clr;
        rpt_if.rpt_ready = ready;
        #1;
        if (rpt_if.rpt_valid && rpt_if.rpt_ready) begin
            has = (exp_q.size() > 0);
            check("sb_pending", {31'd0, has}, 32'd1);
            if (has) check("sb_len", {24'd0, rpt_if.rpt_len}, {24'd0, exp_q.pop_front()});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ready = 1'b0;
        rst = 1'b1;
        cyc(P_0, 1'b0);
        cyc(P_0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(P_0, 1'b0);
    endtask

    task automatic clear_err();
        cyc(P_0, 1'b1);
        check("clr_state", {30'd0, trk_state}, 32'd0);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_state", {30'd0, trk_state}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_code", {30'd0, err_code}, 32'd0);
        check("rst_valid", {31'd0, rpt_if.rpt_valid}, 32'd0);
        check("rst_len", {24'd0, rpt_if.rpt_len}, 32'd0);
        check("rst_ovf", {31'd0, rpt_ovf}, 32'd0);
        check("rst_cnt", {24'd0, round_cnt}, 32'd0);

        // d@t0, e@t0+4, h@t0+9 -> rpt_len 10
        cyc(P_D, 1'b0);
        check("r1_runa", {30'd0, trk_state}, 32'd1);
        idle_n(3);
        cyc(P_E, 1'b0);
        check("r1_runb", {30'd0, trk_state}, 32'd2);
        idle_n(4);
        exp_q.push_back(8'd10);
        cyc(P_H, 1'b0);
        check("r1_idle", {30'd0, trk_state}, 32'd0);
        check("r1_valid", {31'd0, rpt_if.rpt_valid}, 32'd1);
        check("r1_len", {24'd0, rpt_if.rpt_len}, 32'd10);
        check("r1_cnt", {24'd0, round_cnt}, 32'd1);
        ready = 1'b1;
        cyc(P_I, 1'b0);
        check("r1_drop", {31'd0, rpt_if.rpt_valid}, 32'd0);

        // Transfer and new completion on the same edge
        ready = 1'b0;
        cyc(P_D, 1'b0); cyc(P_E, 1'b0);
        exp_q.push_back(8'd3);
        cyc(P_H, 1'b0);
        check("sim_len3", {24'd0, rpt_if.rpt_len}, 32'd3);
        cyc(P_D, 1'b0); cyc(P_E, 1'b0); idle_n(2);
        check("sim_hold", {24'd0, rpt_if.rpt_len}, 32'd3);
        ready = 1'b1;
        exp_q.push_back(8'd5);
        cyc(P_H, 1'b0);
        check("sim_valid", {31'd0, rpt_if.rpt_valid}, 32'd1);
        check("sim_len5", {24'd0, rpt_if.rpt_len}, 32'd5);
        check("sim_ovf", {31'd0, rpt_ovf}, 32'd0);
        check("sim_cnt", {24'd0, round_cnt}, 32'd3);
        cyc(P_I, 1'b0);

        // Overflow: second completion while first report pending
        ready = 1'b0;
        cyc(P_D, 1'b0); cyc(P_E, 1'b0); cyc(P_0, 1'b0);
        exp_q.push_back(8'd4);
        cyc(P_H, 1'b0);
        cyc(P_D, 1'b0); cyc(P_E, 1'b0); cyc(P_H, 1'b0);
        check("ovf_len", {24'd0, rpt_if.rpt_len}, 32'd4);
        check("ovf_valid", {31'd0, rpt_if.rpt_valid}, 32'd1);
        check("ovf_flag", {31'd0, rpt_ovf}, 32'd1);
        check("ovf_cnt", {24'd0, round_cnt}, 32'd5);
        ready = 1'b1;
        cyc(P_I, 1'b0);
        check("ovf_drop", {31'd0, rpt_if.rpt_valid}, 32'd0);
        check("ovf_sticky", {31'd0, rpt_ovf}, 32'd1);

        // Reset with a report pending, then reset mid-round
        ready = 1'b0;
        cyc(P_D, 1'b0); cyc(P_E, 1'b0); cyc(P_H, 1'b0);
        check("pend_valid", {31'd0, rpt_if.rpt_valid}, 32'd1);
        do_reset();
        check("prst_valid", {31'd0, rpt_if.rpt_valid}, 32'd0);
        check("prst_len", {24'd0, rpt_if.rpt_len}, 32'd0);
        check("prst_ovf", {31'd0, rpt_ovf}, 32'd0);
        check("prst_cnt", {24'd0, round_cnt}, 32'd0);
        cyc(P_D, 1'b0); cyc(P_E, 1'b0);
        do_reset();
        check("mrst_state", {30'd0, trk_state}, 32'd0);
        cyc(P_H, 1'b0);
        check("mrst_h_state", {30'd0, trk_state}, 32'd3);
        check("mrst_h_code", {30'd0, err_code}, 32'd1);
        clear_err();
        check("mrst_clr_err", {31'd0, err}, 32'd0);
        check("mrst_clr_code", {30'd0, err_code}, 32'd0);

        // 256 minimum-length rounds -> round_cnt wraps to 0
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            cyc(P_D, 1'b0);
            cyc(P_E, 1'b0);
            exp_q.push_back(8'd3);
            cyc(P_H, 1'b0);
        end
        cyc(P_I, 1'b0);
        check("wrap_cnt", {24'd0, round_cnt}, 32'd0);
        check("wrap_valid", {31'd0, rpt_if.rpt_valid}, 32'd0);

        // Multi-pulse in RUNA; ERR ignores pulses; err_clr outside ERR is inert
        cyc(P_D, 1'b0);
        cyc(P_D | P_E, 1'b0);
        check("multi_state", {30'd0, trk_state}, 32'd3);
        check("multi_err", {31'd0, err}, 32'd1);
        check("multi_code", {30'd0, err_code}, 32'd2);
        cyc(P_H, 1'b0); cyc(P_C | P_D | P_E | P_H, 1'b0); cyc(P_D, 1'b0);
        check("err_hold", {30'd0, trk_state}, 32'd3);
        check("err_code_hold", {30'd0, err_code}, 32'd2);
        check("err_cnt", {24'd0, round_cnt}, 32'd0);
        check("err_noreport", {31'd0, rpt_if.rpt_valid}, 32'd0);
        clear_err();
        check("clr_err", {31'd0, err}, 32'd0);
        check("clr_code", {30'd0, err_code}, 32'd0);
        cyc(P_D, 1'b1);
        check("clr_inert", {30'd0, trk_state}, 32'd1);
        cyc(P_E, 1'b0);
        exp_q.push_back(8'd3);
        cyc(P_H, 1'b0);
        cyc(P_I, 1'b0);
        check("post_clr_cnt", {24'd0, round_cnt}, 32'd1);
        cyc(P_E | P_H, 1'b0);
        check("idle_multi_code", {30'd0, err_code}, 32'd2);
        clear_err();

        // Timeout in RUNA at MAX_LEN
        cyc(P_D, 1'b0);
        idle_n(MAX_LEN - 1);
        check("to_edge_state", {30'd0, trk_state}, 32'd1);
        cyc(P_0, 1'b0);
        check("to_state", {30'd0, trk_state}, 32'd3);
        check("to_code", {30'd0, err_code}, 32'd3);
        check("to_noreport", {31'd0, rpt_if.rpt_valid}, 32'd0);
        check("to_cnt", {24'd0, round_cnt}, 32'd1);
        clear_err();
        cyc(P_H, 1'b0);
        check("idle_h_code", {30'd0, err_code}, 32'd1);
        clear_err();

        // Illegal beats timeout on the same cycle
        cyc(P_D, 1'b0);
        idle_n(MAX_LEN - 1);
        cyc(P_C, 1'b0);
        check("ill_vs_to", {30'd0, err_code}, 32'd1);
        clear_err();

        // Timeout in RUNB, and a legal h exactly at the limit
        cyc(P_D, 1'b0); cyc(P_E, 1'b0);
        idle_n(MAX_LEN - 2);
        check("runb_edge", {30'd0, trk_state}, 32'd2);
        cyc(P_0, 1'b0);
        check("runb_to_code", {30'd0, err_code}, 32'd3);
        clear_err();
        cyc(P_D, 1'b0); cyc(P_E, 1'b0);
        idle_n(MAX_LEN - 2);
        exp_q.push_back(8'(MAX_LEN + 1));
        cyc(P_H, 1'b0);
        check("lim_state", {30'd0, trk_state}, 32'd0);
        cyc(P_I, 1'b0);

        // Illegal c in RUNB
        cyc(P_D, 1'b0); cyc(P_E, 1'b0); cyc(P_C, 1'b0);
        check("runb_c_code", {30'd0, err_code}, 32'd1);
        clear_err();

        // Idle-hold behaviour
        cyc(P_C, 1'b0);
        check("idle_c", {30'd0, trk_state}, 32'd0);
        cyc(P_0, 1'b0);
`ifdef FSM_DEC_STRICT_IDLE_EN
        check("idle_silent_state", {30'd0, trk_state}, 32'd3);
        check("idle_silent_code", {30'd0, err_code}, 32'd1);
        clear_err();
`else
        check("idle_silent_state", {30'd0, trk_state}, 32'd0);
        check("idle_silent_err", {31'd0, err}, 32'd0);
`endif

        check("sb_drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
